// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the loadable, pausable down-counter.
package down_timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/down_timer.sv
// Modulo-N down-counter: counts a loaded value to zero on qualified ticks,
// pulses done at terminal count and optionally reloads for periodic operation.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_e           state;
  logic [WIDTH-1:0] reload;

  // Priority per cycle: load > pause > start > tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        cnt    <= load_val;
        reload <= load_val;
        state  <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start && (cnt != '0)) state <= ST_RUN;
          end
          ST_RUN: begin
            if (pause) begin
              state <= ST_PAUSE;
            end else if (tick_i) begin
              if (cnt == WIDTH'(1)) begin
                done <= 1'b1;
                if (auto_reload && (reload != '0)) begin
                  cnt <= reload;
                end else begin
                  cnt   <= '0;
                  state <= ST_IDLE;
                end
              end else if (cnt > WIDTH'(1)) begin
                cnt <= cnt - WIDTH'(1);
              end
            end
          end
          ST_PAUSE: begin
            if (start && !pause) state <= ST_RUN;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign zero = (cnt == '0);

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: directed scenarios plus random stimulus
// against a behavioural model of the timer.
module tb_down_timer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rstn;
  logic         tick_i;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         pause;
  logic         auto_reload;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  logic         zero;

  down_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tick_i     (tick_i),
    .load       (load),
    .load_val   (load_val),
    .start      (start),
    .pause      (pause),
    .auto_reload(auto_reload),
    .cnt        (cnt),
    .busy       (busy),
    .done       (done),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cnt;
    bit          busy;
    bit          done;
    bit          zero;
    int          idx;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int drv_idx = 0;
  int done_seen = 0;
  int last_done_idx = -1;

  // Reference model: remaining count, captured period, and activity flags.
  int unsigned m_cnt = 0;
  int unsigned m_period = 0;
  bit          m_active = 0;
  bit          m_paused = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input bit ld, input int unsigned lv, input bit st, input bit ps,
                      input bit tk, input bit ar);
    exp_t e;
    bit   fire;
    @(negedge clk);
    load        = ld;
    load_val    = W'(lv);
    start       = st;
    pause       = ps;
    tick_i      = tk;
    auto_reload = ar;
    fire = 0;
    if (ld) begin
      m_cnt    = lv % (1 << W);
      m_period = m_cnt;
      m_active = 0;
      m_paused = 0;
    end else if (!m_active) begin
      if (st && m_cnt != 0) m_active = 1;
    end else if (m_paused) begin
      if (st && !ps) m_paused = 0;
    end else if (ps) begin
      m_paused = 1;
    end else if (tk && m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        fire = 1;
        if (ar && m_period != 0) m_cnt = m_period;
        else m_active = 0;
      end
    end
    e.cnt  = m_cnt;
    e.busy = m_active;
    e.done = fire;
    e.zero = (m_cnt == 0);
    e.idx  = drv_idx;
    drv_idx++;
    sb_q.push_back(e);
  endtask

  task automatic idle_steps(input int n, input bit tk, input bit ar);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, tk, ar);
  endtask

  // Monitor: compare every observed cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk($sformatf("cnt[%0d]", e.idx), cnt, e.cnt);
        chk($sformatf("busy[%0d]", e.idx), busy, e.busy);
        chk($sformatf("done[%0d]", e.idx), done, e.done);
        chk($sformatf("zero[%0d]", e.idx), zero, e.zero);
        if (done) begin
          done_seen++;
          last_done_idx = e.idx;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_idx;
    int d0;
    rstn = 1'b0;
    tick_i = 0; load = 0; load_val = '0; start = 0; pause = 0; auto_reload = 0;
    #1;
    chk("reset_cnt", cnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_zero", zero, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // One-shot: 3,2,1,0 with done on the 0 cycle.
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    start_idx = drv_idx - 1;
    d0 = done_seen;
    idle_steps(5, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("oneshot_done_count", done_seen - d0, 1);
    chk("oneshot_latency", last_done_idx - start_idx, 3);

    // Periodic: load 4, auto reload, then clear auto_reload.
    step(1, 4, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 1);
    d0 = done_seen;
    idle_steps(12, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("periodic_done_count", done_seen - d0, 3);
    idle_steps(6, 1, 0);

    // Sparse ticks: load 2, tick every 10 cycles.
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    start_idx = drv_idx - 1;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, (i % 10) == 9, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("sparse_latency", last_done_idx - start_idx, 20);

    // Pause at cnt=1, ticks present, then resume.
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    idle_steps(30, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    d0 = done_seen;
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("resume_done_count", done_seen - d0, 1);

    // Load while running at cnt=2 with tick high aborts silently.
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 7, 0, 0, 1, 0);
    idle_steps(3, 1, 0);

    // Zero load: start ignored.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    idle_steps(3, 1, 0);

    // All-ones load: done after exactly 255 ticks, no wrap.
    step(1, 255, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    start_idx = drv_idx - 1;
    d0 = done_seen;
    idle_steps(260, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("max_done_count", done_seen - d0, 1);
    chk("max_latency", last_done_idx - start_idx, 255);

    // Async reset mid-run at cnt=5.
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    load = 0; start = 0; pause = 0; tick_i = 0; auto_reload = 0;
    #2 rstn = 1'b0;
    #1;
    chk("midrun_reset_cnt", cnt, 0);
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_done", done, 0);
    chk("midrun_reset_zero", zero, 1);
    m_cnt = 0; m_period = 0; m_active = 0; m_paused = 0;
    @(negedge clk);
    rstn = 1'b1;
    step(0, 0, 1, 0, 1, 1);
    idle_steps(3, 1, 1);

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      bit          ld;
      int unsigned lv;
      ld = ($urandom_range(0, 99) < 4);
      lv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      step(ld, lv,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
